display_scan_decoder: RTL and testbench
=======================================

Name: display_scan_decoder

Overview:
- Receive side of the multiplexed 7-segment display interface.
- Samples the scanned segment bus and its digit-select lines, converts segment patterns back to BCD, and assembles complete four-digit time frames (Min1, Min2, Hour1, Hour2).
- Used for display loopback self-check and by the verification environment to read displayed time without a segment-level model.

Parameters:
- STABLE_CYC, 4: consecutive cycles with unchanged seg and dsel before a digit is captured; legal range 1..15.
- CNT_W, 4: width of the stability counter; must satisfy 2^CNT_W > STABLE_CYC.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset
- seg  input  8  segment bus, active-high; bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g, bit7=dp (dp ignored)
- dsel  input  2  digit select: 0=Min1, 1=Min2, 2=Hour1, 3=Hour2
- Min1  output  4  decoded minute units
- Min2  output  4  decoded minute tens
- Hour1  output  4  decoded hour units
- Hour2  output  4  decoded hour tens
- frame_valid  output  1  one-cycle pulse; all four outputs were just updated
- seg_err  output  1  one-cycle pulse; an illegal pattern was captured
- range_err  output  1  one-cycle pulse; frame rejected by the range check (RANGE_CHECK_EN only)

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs: Min1/Min2/Hour1/Hour2 = 0; frame_valid, seg_err, range_err = 0.
  - Internal state: input regs s_seg=0, s_sel=0; stability counter=0; captured mask=4'b0000; state=DWELL.
- Input stage: seg[6:0] and dsel are registered into s_seg and s_sel every cycle. No other use of raw inputs.
- Stability counter:
  - Cleared to 0 when the new s_seg or s_sel differs from its previous value.
  - Otherwise increments, saturating at STABLE_CYC.
- State machine:
  - DWELL: when the counter reaches STABLE_CYC, capture s_seg into slot s_sel, then go to HOLD.
  - HOLD: no further captures. Return to DWELL on any change of s_seg or s_sel.
  - Result: exactly one capture per stable dwell.
- Decode table (s_seg[6:0] hex -> BCD):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9.
  - 00 (blank) -> 0, legal.
  - Any other pattern is illegal.
- Legal capture:
  - Write the digit into the shadow register for the slot and set the mask bit.
  - Recapturing an already-set slot overwrites the shadow value; mask unchanged.
- Illegal capture:
  - seg_err pulses 1 cycle (the cycle after the capture edge).
  - Mask is cleared to 0000; the current partial frame is discarded.
- Frame completion:
  - Trigger: a capture makes mask=1111.
  - On the next edge, all four outputs load from the shadows simultaneously, frame_valid pulses for 1 cycle, and mask clears.
  - Outputs hold their values between frames.
- Latency: the last segment change of the completing digit to frame_valid is STABLE_CYC+2 cycles (1 input register + STABLE_CYC dwell + 1 output load).
- Simultaneous events: a capture in the same cycle as the completion load is accepted into the freshly cleared mask; it is not lost.
- Reset mid-frame: partial frame discarded; outputs return to 0.
- Glitches shorter than STABLE_CYC cycles are never captured.

Optional Feature:
- Macro: RANGE_CHECK_EN.
- Defined:
  - At completion, the frame is checked for Min2<=5, Hour2<=2, and Hour2*10+Hour1<=23.
  - Pass: normal frame load.
  - Fail: outputs unchanged, range_err pulses 1 cycle instead of frame_valid, mask cleared.
- Undefined: no check is performed; range_err is tied to 0.

Test Plan:
- Reset then idle with dsel=0, seg=00 -> all outputs 0; no frame_valid; no seg_err.
- Scan dsel 0,1,2,3 with seg 7D,4F,5B,06 (time 12:36), each held 8 cycles -> a single frame_valid pulse STABLE_CYC+2 cycles after the dsel=3 segment change; outputs Min1=6, Min2=3, Hour1=2, Hour2=1.
- Hold dsel=1 seg=6D for 3 cycles, then seg=06 for 8 cycles (STABLE_CYC=4) -> only 1 is captured into Min2; the 3-cycle glitch is ignored.
- Mid-frame, capture seg=55 on dsel=2 -> seg_err pulses once; the next full scan is needed before frame_valid; outputs hold their old frame until then.
- Assert reset for 1 cycle after slots 0–2 are captured -> outputs 0; the following scan of slot 3 alone gives no frame_valid.
- RANGE_CHECK_EN with a scan of Hour2=2, Hour1=5 (25:00) -> range_err pulses and outputs are unchanged. Without the macro, frame_valid pulses and Hour1=5, Hour2=2.

Source files
------------

// File: rtl/display_scan_decoder.sv
// display_scan_decoder: rebuilds four-digit time frames from a scanned 7-segment bus (optional range check under RANGE_CHECK_EN)
module display_scan_decoder #(
  parameter int STABLE_CYC = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seg,
  input  logic [1:0] dsel,
  output logic [3:0] Min1,
  output logic [3:0] Min2,
  output logic [3:0] Hour1,
  output logic [3:0] Hour2,
  output logic       frame_valid,
  output logic       seg_err,
  output logic       range_err
);
  typedef enum logic {DWELL, HOLD} state_t;
  state_t state_q;
  logic [6:0] s_seg_q;
  logic [1:0] s_sel_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0][3:0] sh_q;
  logic chg, cap, legal, done, rng_ok;
  logic [3:0] dig;
  logic unused_dp;
  assign unused_dp = seg[7];
  // change detect, dwell capture strobe, pattern decode and next capture mask
  always_comb begin
    chg = seg[6:0] != s_seg_q || dsel != s_sel_q;
    cnt_d = chg ? '0 : cnt_q == CNT_W'(STABLE_CYC) ? cnt_q : cnt_q + 1'b1;
    cap = state_q == DWELL && !chg && cnt_q == CNT_W'(STABLE_CYC - 1);
    legal = 1'b1;
    dig = 4'd0;
    case (s_seg_q)
      7'h3F: dig = 4'd0;
      7'h06: dig = 4'd1;
      7'h5B: dig = 4'd2;
      7'h4F: dig = 4'd3;
      7'h66: dig = 4'd4;
      7'h6D: dig = 4'd5;
      7'h7D: dig = 4'd6;
      7'h07: dig = 4'd7;
      7'h7F: dig = 4'd8;
      7'h6F: dig = 4'd9;
      7'h00: dig = 4'd0;
      default: legal = 1'b0;
    endcase
    done = mask_q == 4'hF;
    mask_d = done ? 4'h0 : mask_q;
    mask_d = !cap ? mask_d : legal ? mask_d | (4'b1 << s_sel_q) : 4'h0;
`ifdef RANGE_CHECK_EN
    rng_ok = sh_q[1] <= 4'd5 && sh_q[3] <= 4'd2 && 7'(sh_q[3]) * 7'd10 + 7'(sh_q[2]) <= 7'd23;
`else
    rng_ok = 1'b1;
`endif
  end
  // input stage, dwell/hold FSM, shadow capture and simultaneous frame load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_seg_q <= '0;
      s_sel_q <= '0;
      cnt_q <= '0;
      state_q <= DWELL;
      mask_q <= '0;
      sh_q <= '0;
      {Hour2, Hour1, Min2, Min1} <= '0;
      frame_valid <= 1'b0;
      seg_err <= 1'b0;
    end else begin
      s_seg_q <= seg[6:0];
      s_sel_q <= dsel;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      state_q <= chg ? DWELL : cap ? HOLD : state_q;
      if (cap && legal) sh_q[s_sel_q] <= dig;
      if (done && rng_ok) {Hour2, Hour1, Min2, Min1} <= sh_q;
      frame_valid <= done && rng_ok;
      seg_err <= cap && !legal;
    end
  end
`ifdef RANGE_CHECK_EN
  // completed frames outside 00:00..23:59 pulse range_err instead of loading
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) range_err <= 1'b0;
    else range_err <= done && !rng_ok;
  end
`else
  assign range_err = 1'b0;
`endif
endmodule

// File: tb/tb_display_scan_decoder.sv
// tb_display_scan_decoder: scoreboard bench with a dwell-level reference model of the scan decoder
module tb_display_scan_decoder;
  localparam int S = 4;
  typedef struct {int c; logic [15:0] v;} fr_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] seg = 8'h00;
  logic [1:0] dsel = 2'd0;
  logic [3:0] Min1, Min2, Hour1, Hour2;
  logic frame_valid, seg_err, range_err;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  fr_t fq[$];
  int eq[$];
  int rq[$];
  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [3:0] msh [4];
  logic [3:0] mmask;
  logic [1:0] cur_sel;
  logic [6:0] cur_pat;
  logic [15:0] cur;
  logic [15:0] outs;
  fr_t f;
  int e;

  display_scan_decoder #(.STABLE_CYC(S), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .seg(seg), .dsel(dsel),
    .Min1(Min1), .Min2(Min2), .Hour1(Hour1), .Hour2(Hour2),
    .frame_valid(frame_valid), .seg_err(seg_err), .range_err(range_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign outs = {Hour2, Hour1, Min2, Min1};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // a digit captured at edge ce: update slots, predict frame/error events
  task automatic model_cap(input logic [1:0] s, input logic [6:0] p, input int ce);
    int d;
    logic [15:0] v;
    bit ok;
    d = (p == 7'h00) ? 0 : -1;
    for (int i = 0; i < 10; i++) if (pats[i] == p) d = i;
    if (d < 0) begin
      eq.push_back(ce);
      mmask = 4'h0;
    end else begin
      msh[s] = 4'(d);
      mmask[s] = 1'b1;
      if (mmask == 4'hF) begin
        v = {msh[3], msh[2], msh[1], msh[0]};
        ok = 1'b1;
`ifdef RANGE_CHECK_EN
        ok = msh[1] <= 5 && msh[3] <= 2 && int'(msh[3]) * 10 + int'(msh[2]) <= 23;
`endif
        if (ok) fq.push_back('{c: ce + 1, v: v});
        else rq.push_back(ce + 1);
        mmask = 4'h0;
      end
    end
  endtask

  task automatic dwell(input logic [1:0] s, input logic [6:0] p, input int h);
    seg = {1'($urandom), p};
    dsel = s;
    cur_sel = s;
    cur_pat = p;
    if (h >= S + 1) model_cap(s, p, cyc + 1 + S);
    repeat (h) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    repeat (S + 3) @(posedge clk);
    #1;
    model_cap(2'd0, 7'h00, cyc);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && (fq.size() + eq.size() + rq.size()) != 0; i++) @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    drain();
    seg = 8'h00;
    dsel = 2'd0;
    reset = 1'b0;
    mmask = 4'h0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cur_sel = 2'd0;
    cur_pat = 7'h00;
    idle();
  endtask

  // monitor: pops expected events when the DUT presents them, checks hold between frames
  initial begin
    cur = 16'h0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("reset_state", {outs, frame_valid, seg_err, range_err}, 32'h0);
        cur = 16'h0;
      end else begin
        if (frame_valid) begin
          if (fq.size() == 0) chk("fv_unexpected", frame_valid, 1'b0);
          else begin
            f = fq.pop_front();
            chk("fv_cycle", cyc, f.c);
            chk("frame", outs, f.v);
            cur = f.v;
          end
        end else chk("hold", outs, cur);
        if (seg_err) begin
          if (eq.size() == 0) chk("seg_err_unexpected", seg_err, 1'b0);
          else begin
            e = eq.pop_front();
            chk("seg_err_cycle", cyc, e);
          end
        end
        if (range_err) begin
          if (rq.size() == 0) chk("range_err_unexpected", range_err, 1'b0);
          else begin
            e = rq.pop_front();
            chk("range_err_cycle", cyc, e);
          end
        end
        if (fq.size() != 0 && fq[0].c < cyc) begin
          chk("fv_missed", cyc, fq[0].c);
          void'(fq.pop_front());
        end
        if (eq.size() != 0 && eq[0] < cyc) begin
          chk("seg_err_missed", cyc, eq[0]);
          void'(eq.pop_front());
        end
        if (rq.size() != 0 && rq[0] < cyc) begin
          chk("range_err_missed", cyc, rq[0]);
          void'(rq.pop_front());
        end
      end
    end
  end

  initial begin
    logic [1:0] s;
    logic [6:0] p;
    int r;
    mmask = 4'h0;
    cur_sel = 2'd0;
    cur_pat = 7'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    idle();
    dwell(2'd0, 7'h7D, 8);
    dwell(2'd1, 7'h4F, 8);
    dwell(2'd2, 7'h5B, 8);
    dwell(2'd3, 7'h06, 8);
    drain();
    dwell(2'd1, 7'h6D, 3);
    dwell(2'd1, 7'h06, 8);
    dwell(2'd0, 7'h3F, 8);
    dwell(2'd2, 7'h55, 8);
    dwell(2'd0, 7'h3F, 8);
    dwell(2'd1, 7'h06, 8);
    dwell(2'd2, 7'h66, 8);
    dwell(2'd3, 7'h06, 8);
    drain();
    dwell(2'd0, 7'h5B, 8);
    dwell(2'd1, 7'h4F, 8);
    dwell(2'd2, 7'h07, 8);
    rst_pulse();
    dwell(2'd3, 7'h06, 8);
    drain();
    dwell(2'd1, 7'h55, 8);
    dwell(2'd0, 7'h3F, 8);
    dwell(2'd1, 7'h3F, 8);
    dwell(2'd2, 7'h6D, 8);
    dwell(2'd3, 7'h5B, 8);
    drain();
    for (int i = 0; i < 300; i++) begin
      do begin
        s = 2'($urandom_range(0, 3));
        r = $urandom_range(0, 19);
        p = r < 16 ? pats[r % 10] : r < 18 ? 7'h00 : 7'($urandom);
      end while (s == cur_sel && p == cur_pat);
      dwell(s, p, $urandom_range(0, 3) == 0 ? $urandom_range(1, S) : $urandom_range(S + 1, S + 4));
      if (i == 150) rst_pulse();
    end
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("queues_empty", fq.size() + eq.size() + rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
